// File: rtl/pulse_train_gen_pkg.sv
// Shared types and defaults for the pulse train generator.
package pulse_train_pkg;

   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

endpackage

// File: rtl/pulse_train_gen_if.sv
// Control/waveform bundle between the controller (master) and the generator (slave).
interface pulse_train_gen_if import pulse_train_pkg::*; #(
   parameter int CNT_W = CNT_W_DEF
) ();

   logic             start;
   logic             abort;
   logic [CNT_W-1:0] high_len;
   logic [CNT_W-1:0] low_len;
   logic [CNT_W-1:0] num_pulses;
   logic             wave;
   logic             busy;
   logic             done;

   modport master (
      output start, abort, high_len, low_len, num_pulses,
      input  wave, busy, done
   );

   modport slave (
      input  start, abort, high_len, low_len, num_pulses,
      output wave, busy, done
   );

endinterface

// File: rtl/pulse_train_gen_phase_counter.sv
// Loadable down-counter timing one high or low phase; a zero load is clamped to 1.
module phase_counter import pulse_train_pkg::*; #(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_value,
   output logic             o_expire
);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_clamped;

   assign w_clamped = (i_load_value == '0) ? CNT_W'(1) : i_load_value;

   // Parks at zero so an abandoned phase never wraps into a false expire.
   always_ff @(posedge clk) begin
      if (resetn) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= w_clamped;
      end else if (r_count != '0) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_expire = (r_count == CNT_W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Emits N pulses of latched high/low widths per accepted start; outputs are all flopped.
module pulse_train_gen import pulse_train_pkg::*; #(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               resetn,
   pulse_train_gen_if.slave   bus
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_high_len;
   logic [CNT_W-1:0] r_low_len;
   logic [CNT_W-1:0] r_pulses;
   logic             r_wave;
   logic             r_busy;
   logic             r_done;

   logic             w_load;
   logic [CNT_W-1:0] w_load_value;
   logic             w_expire;
   logic             w_latch;
   logic             w_pulse_dec;
   logic             w_done_nxt;

   phase_counter #(.CNT_W(CNT_W)) u_phase (
      .clk          (clk),
      .resetn       (resetn),
      .i_load       (w_load),
      .i_load_value (w_load_value),
      .o_expire     (w_expire)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_load       = 1'b0;
      w_load_value = r_high_len;
      w_latch      = 1'b0;
      w_pulse_dec  = 1'b0;
      w_done_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            // abort beats a simultaneous start; a zero-pulse start only strobes done.
            if (bus.start && !bus.abort) begin
               if (bus.num_pulses != '0) begin
                  w_latch      = 1'b1;
                  w_load       = 1'b1;
                  w_load_value = bus.high_len;
                  w_state_nxt  = HIGH;
               end else begin
                  w_done_nxt   = 1'b1;
               end
            end
         end
         HIGH: begin
            if (bus.abort) begin
               w_state_nxt = IDLE;
            end else if (w_expire) begin
               w_load       = 1'b1;
               w_load_value = r_low_len;
               w_state_nxt  = LOW;
            end
         end
         LOW: begin
            if (bus.abort) begin
               w_state_nxt = IDLE;
            end else if (w_expire) begin
               w_pulse_dec = 1'b1;
               if (r_pulses > CNT_W'(1)) begin
                  w_load       = 1'b1;
                  w_load_value = r_high_len;
                  w_state_nxt  = HIGH;
               end else begin
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so wave rises one cycle after start.
   always_ff @(posedge clk) begin
      if (resetn) begin
         r_state    <= IDLE;
         r_high_len <= '0;
         r_low_len  <= '0;
         r_pulses   <= '0;
         r_wave     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_latch) begin
            r_high_len <= bus.high_len;
            r_low_len  <= bus.low_len;
            r_pulses   <= bus.num_pulses;
         end else if (w_pulse_dec) begin
            r_pulses   <= r_pulses - CNT_W'(1);
         end
         r_wave <= (w_state_nxt == HIGH);
         r_busy <= (w_state_nxt != IDLE);
         r_done <= w_done_nxt;
      end
   end

   assign bus.wave = r_wave;
   assign bus.busy = r_busy;
   assign bus.done = r_done;

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Generates a programmable train of rectangular pulses on a single-bit output from one start request, the transmit-side counterpart of the team's edge-detection logic. Each start produces N high pulses of configurable high and low widths, measured in clock cycles. Downstream edge detectors recover exactly N rising and N falling edges. The block sits between control logic, which issues start and abort strobes, and any level-sensitive consumer of the waveform.

## Interface
- CNT_W, 8: width of the high_len, low_len and num_pulses inputs and of the internal counters.
- clk  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  synchronous reset, active-high despite the name; sampled on the rising clk edge.
- start  in  1  single-cycle request; honoured only in IDLE.
- abort  in  1  single-cycle request; terminates the train.
- high_len  in  CNT_W  cycles per high phase; latched on an accepted start.
- low_len  in  CNT_W  cycles per low phase; latched on an accepted start.
- num_pulses  in  CNT_W  number of pulses; latched on an accepted start.
- wave  out  1  generated waveform; registered.
- busy  out  1  high while a train is in progress; registered.
- done  out  1  one-cycle completion strobe; registered.

## Operation
- FSM states: IDLE, HIGH, LOW.
- Reset: state goes to IDLE, and wave, busy, done and all counters are cleared to 0. This applies at any point, including mid-train.
- IDLE with start=1, abort=0 and num_pulses>0:
  - Latch the configuration.
  - Load the phase counter with the high length.
  - Load the pulse counter with num_pulses.
  - Go to HIGH.
- HIGH: wave=1. When the phase counter expires, reload it with the low length and go to LOW.
- LOW: wave=0. When the phase counter expires:
  - Decrement the pulse counter.
  - If pulses remain, reload the high length and go to HIGH.
  - Otherwise go to IDLE and assert done for one cycle.
- Zero-width clamp: high_len=0 or low_len=0 is treated as 1.
- start with num_pulses=0 in IDLE: no waveform activity and busy stays 0. done pulses in the following cycle.
- start while busy: ignored, and the configuration is not re-latched.
- abort in HIGH or LOW: go to IDLE next cycle with wave=0 and busy=0. done is not asserted.
- abort in IDLE: no effect. If start and abort arrive in the same IDLE cycle, abort wins and start is dropped.
- Configuration inputs may change freely while busy; only the latched copy is used.

## Timing
- Notation: start accepted at clock edge t. H and L are the clamped widths; N is the pulse count.
- wave is 1 in cycles t+1..t+H, then 0 in cycles t+H+1..t+H+L. This repeats N times, with pulse k beginning at cycle t+1+(k-1)(H+L).
- busy is 1 in cycles t+1..t+N(H+L). done is 1 in cycle t+N(H+L)+1 only, with busy=0 in that cycle.
- A new start may be accepted in the done cycle. Its first high cycle then immediately follows the done cycle.
- abort sampled at edge a during a train: wave=0 and busy=0 from cycle a+1.
- Latency from start to the first rising edge of wave is 1 cycle.
- Period is H+L cycles. There are no idle cycles between pulses within a train.
- Maximum train length: (2^CNT_W−1) pulses × 2(2^CNT_W−1) cycles. The counters must not wrap inside a train.

## Structure
- Package pulse_train_pkg holds:
  - the state_t enum (IDLE, HIGH, LOW), 2-bit encoding;
  - the CNT_W default constant.
- One sub-module, phase_counter: a loadable CNT_W down-counter.
  - Inputs: load and load_value (the clamp is applied at load).
  - Output: expire, asserted when the count equals 1.
  - Instantiated once for the phase timing. The pulse count is a plain register in the top level.
- All outputs are driven directly from flops; there is no combinational path from inputs to outputs.

## Test plan
- Reset/basic train: reset mid-train with H=3, L=2, N=4 → wave, busy and done are 0 the next cycle. After reset release, run H=3, L=2, N=4 → wave is high at t+1..t+3, t+6..t+8, t+11..t+13, t+16..t+18; busy spans t+1..t+20; done pulses at t+21.
- Clamp and zero count: H=0, L=0, N=3 → wave pattern 1,0,1,0,1,0 and done at t+7. N=0 → busy stays 0 and done pulses at t+1.
- Abort: H=5, L=5, N=10, abort at t+12 → wave=0 and busy=0 at t+13; no done ever appears.
- Start conflicts:
  - Start during busy with a changed config → the original train completes unchanged.
  - start and abort together in IDLE → nothing happens.
- Back-to-back: start asserted in the done cycle with H=1, L=1, N=2 → the next high cycle immediately follows done.
- Edge-count check: random H, L in 1..15 and N in 1..20 → count exactly N rising and N falling edges on wave, and exactly one done per train.
